// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its picker.
package uart_pkg;

  localparam int ByteW = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_HI,
    WAIT_LO,
    HOLD
  } arbState_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first request searching upward from ptr+1.
module rr_picker
  import uart_pkg::*;
#(
  parameter  int NumReq = 4,
  localparam int IdW    = clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] grantOneHot,
  output logic [IdW-1:0]    grantIdx,
  output logic              anyReq
);

  always_comb begin
    logic [IdW-1:0] cand;
    cand        = '0;
    grantOneHot = '0;
    grantIdx    = '0;
    anyReq      = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdW'((int'(ptr) + k) % NumReq);
      if (!anyReq && req[cand]) begin
        anyReq            = 1'b1;
        grantIdx          = cand;
        grantOneHot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one 8N1 byte transmitter among NumReq sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NumReq       = 4,
  parameter  int HoldTimeout  = 1024,
  parameter  int StartTimeout = 4,
  localparam int IdW          = clog2(NumReq),
  localparam int HoldW        = clog2(HoldTimeout) + 1,
  localparam int StartW       = clog2(StartTimeout) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [ByteW*NumReq-1:0] req_data,
  input  logic [NumReq-1:0]       req_last,
  output logic [NumReq-1:0]       req_ready,
  output logic                    tx_start,
  output logic [ByteW-1:0]        tx_data,
  input  logic                    tx_busy,
  output logic [IdW-1:0]          grant_id,
  output logic                    active,
  output logic                    hold_timeout,
  output logic                    start_err
);

  arbState_t         state, stateNext;
  logic [IdW-1:0]    ptr, ptrNext, grantNext;
  logic [NumReq-1:0] grantMask, grantMaskNext;
  logic              lastQ, lastNext;
  logic [StartW-1:0] startCnt, startCntNext;
  logic [HoldW-1:0]  holdCnt, holdCntNext;
  logic [ByteW-1:0]  dataNext, grantByte;
  logic [NumReq-1:0] readyNext, pickOneHot;
  logic [IdW-1:0]    pickIdx;
  logic              pickAny, startNext, holdToNext, startErrNext;
  logic              ownerValid, ownerLast;

  rr_picker #(.NumReq(NumReq)) picker (
    .req         (req_valid),
    .ptr         (ptr),
    .grantOneHot (pickOneHot),
    .grantIdx    (pickIdx),
    .anyReq      (pickAny)
  );

  assign ownerValid = |(req_valid & grantMask);
  assign ownerLast  = |(req_last & grantMask);

  always_comb begin
    grantByte = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_id == IdW'(i)) grantByte = req_data[i*ByteW +: ByteW];
    end
  end

  always_comb begin
    stateNext     = state;
    ptrNext       = ptr;
    grantNext     = grant_id;
    grantMaskNext = grantMask;
    lastNext      = lastQ;
    startCntNext  = startCnt;
    holdCntNext   = holdCnt;
    dataNext      = tx_data;
    readyNext     = '0;
    startNext     = 1'b0;
    holdToNext    = 1'b0;
    startErrNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pickAny) begin
          grantNext     = pickIdx;
          grantMaskNext = pickOneHot;
          stateNext     = LOAD;
        end
      end
      LOAD: begin
        // Owner dropping valid here just parks us; the hold watchdog is not armed.
        if (!tx_busy && ownerValid) begin
          dataNext     = grantByte;
          startNext    = 1'b1;
          readyNext    = grantMask;
          lastNext     = ownerLast;
          startCntNext = '0;
          stateNext    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          stateNext = WAIT_LO;
        end else if (startCnt >= StartW'(StartTimeout - 1)) begin
          startErrNext = 1'b1;
          stateNext    = WAIT_LO;
        end else begin
          startCntNext = startCnt + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (lastQ) begin
            ptrNext   = grant_id;
            stateNext = IDLE;
          end else if (ownerValid) begin
            stateNext = LOAD;
          end else begin
            holdCntNext = '0;
            stateNext   = HOLD;
          end
        end
      end
      HOLD: begin
        if (ownerValid) begin
          stateNext = LOAD;
        end else if (holdCnt >= HoldW'(HoldTimeout - 1)) begin
          holdToNext = 1'b1;
          ptrNext    = grant_id;
          stateNext  = IDLE;
        end else begin
          holdCntNext = holdCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= IdW'(NumReq - 1);
      grant_id     <= '0;
      grantMask    <= '0;
      lastQ        <= 1'b0;
      startCnt     <= '0;
      holdCnt      <= '0;
      tx_data      <= '0;
      req_ready    <= '0;
      tx_start     <= 1'b0;
      active       <= 1'b0;
      hold_timeout <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      state        <= stateNext;
      ptr          <= ptrNext;
      grant_id     <= grantNext;
      grantMask    <= grantMaskNext;
      lastQ        <= lastNext;
      startCnt     <= startCntNext;
      holdCnt      <= holdCntNext;
      tx_data      <= dataNext;
      req_ready    <= readyNext;
      tx_start     <= startNext;
      active       <= (stateNext != IDLE);
      hold_timeout <= holdToNext;
      start_err    <= startErrNext;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial byte transmitter (8N1 + stop, `TxD_start`/`TxD_data`/`TxD_busy` interface) among NumReq byte-stream requesters.
- Round-robin grant per packet: once a requester wins, it keeps the transmitter until it sends a byte flagged `last`, or until it goes quiet for HoldTimeout cycles.
- Sits between protocol/encoder sources and the transmitter. It owns all `TxD_start` sequencing.

Parameters:
- NumReq, 4, number of requesters (2..8).
- HoldTimeout, 1024, idle cycles a mid-packet owner may stall before its grant is revoked.
- StartTimeout, 4, cycles to wait for `tx_busy` to rise after `tx_start` before flagging an error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- req_valid  in  NumReq  per-requester byte available.
- req_data  in  8*NumReq  byte of requester i on bits [8i+7:8i].
- req_last  in  NumReq  byte is the final one of its packet.
- req_ready  out  NumReq  one-cycle accept pulse; byte consumed.
- tx_start  out  1  to transmitter start input.
- tx_data  out  8  to transmitter data input.
- tx_busy  in  1  from transmitter busy output.
- grant_id  out  clog2(NumReq)  current or most recent owner.
- active  out  1  a grant is held (state != IDLE).
- hold_timeout  out  1  one-cycle pulse when a grant is revoked by HoldTimeout.
- start_err  out  1  one-cycle pulse when `tx_busy` does not rise within StartTimeout.

Behaviour:
- Reset values:
  - `req_ready`, `tx_start`, `tx_data`, `active`, `hold_timeout`, `start_err` = 0.
  - `grant_id` = 0.
  - RR pointer = NumReq-1, so requester 0 wins the first arbitration.
  - State = IDLE.
- The transmitter has no reset. After `rst_n` deasserts while `tx_busy`=1, the block waits in LOAD until `tx_busy`=0.
- Requester handshake:
  - A requester holds `req_valid`, `req_data` and `req_last` stable until it sees its `req_ready` pulse.
  - `req_ready` is never high for more than one bit, or for more than one cycle per byte.
- Outputs are registered. `tx_start` is high for exactly one cycle per byte. `tx_data` is stable from that cycle until the next LOAD.
- FSM:
  - IDLE: if `req_valid` != 0, the winner is the first set bit searching from pointer+1 with wrap-around. Set `grant_id` <= winner, go to LOAD. Otherwise stay.
  - LOAD: when `tx_busy`=0 and `req_valid[grant]`=1:
    - `tx_data` <= the granted byte; pulse `tx_start` and `req_ready[grant]`.
    - Latch `last` <= `req_last[grant]`, clear the watchdog, go to WAIT_HI.
  - WAIT_HI: go to WAIT_LO on `tx_busy`=1. After StartTimeout cycles without it, pulse `start_err` and go to WAIT_LO.
  - WAIT_LO: when `tx_busy`=0:
    - `last`=1: pointer <= grant, go to IDLE.
    - else `req_valid[grant]`=1: go to LOAD.
    - else: go to HOLD and clear the hold counter.
  - HOLD: `req_valid[grant]`=1 goes to LOAD. When the counter reaches HoldTimeout-1, pulse `hold_timeout`, pointer <= grant, go to IDLE.
- Latency: a byte presented to an idle block with idle transmitter gives IDLE->LOAD = 1 cycle, so `tx_start` is high on the 2nd clock edge after `req_valid` rises.
- Back-to-back bytes in one packet: `tx_start` follows 1 cycle after `tx_busy` falls (WAIT_LO->LOAD).
- Non-owners are ignored while a grant is held, even if their `req_valid` is asserted throughout.
- A requester dropping `req_valid` in IDLE before being granted is legal. If it drops in LOAD, the block stays in LOAD and the HOLD rules do not apply.
- Simultaneous requests: strict RR order. With all requesters valid, single-byte packets are granted 0,1,2,3,0,…
- Counters saturate and never wrap. The hold counter is clog2(HoldTimeout)+1 bits.
- Asynchronous reset mid-byte: all outputs clear immediately. The byte already latched by the transmitter completes on the line and is not re-sent.

Decomposition:
- Shared package `uart_pkg`:
  - state enum: IDLE, LOAD, WAIT_HI, WAIT_LO, HOLD.
  - byte width constant 8.
  - clog2 function.
- One sub-module `rr_picker`: combinational round-robin, NumReq request bits + pointer -> one-hot grant + index. Reusable by a future receive-side demux.

Test Plan:
- Single byte: requester 2 sends 0xA5 with `last`=1, transmitter model busy for 10 cycles -> `tx_start` 1 cycle with `tx_data`=0xA5, `req_ready[2]` pulses once, `active` returns to 0, pointer=2.
- Contention: requesters 0,1,3 each present a one-byte packet in the same cycle (0x11, 0x22, 0x33) -> transmitted order 0x11, 0x22, 0x33; `grant_id` sequence 0, 1, 3.
- Packet lock: requester 1 sends 3 bytes (0x01, 0x02, 0x03 with `last` on the 3rd) while requester 0 holds `req_valid` -> all three bytes of 1 go before 0's byte, with no interleave.
- Hold timeout: HoldTimeout=16; requester 3 sends 1 byte without `last`, then drops `req_valid` -> `hold_timeout` pulses 16 cycles after `tx_busy` falls, the block returns to IDLE, and pending requester 0 is granted next.
- Start error: `tx_busy` tied 0 -> `start_err` pulses StartTimeout=4 cycles after `tx_start`, and the block proceeds with no hang.
- Reset mid-byte: assert `rst_n`=0 during WAIT_LO -> outputs clear the same cycle; after release with `tx_busy` still 1, the first new `tx_start` waits until `tx_busy`=0.
